// File: rtl/road_fighter_pkg.sv
// Shared Road Fighter game-logic definitions: fuel FSM encoding, default
// fuel tuning constants used by the HUD and spawn logic, and level clamping.
package road_fighter_pkg;

  typedef enum logic [1:0] {
    FUEL_IDLE  = 2'd0,
    FUEL_RUN   = 2'd1,
    FUEL_LOW   = 2'd2,
    FUEL_EMPTY = 2'd3
  } fuel_state_t;

  localparam int FUEL_MAX_DEFAULT        = 100;
  localparam int FRAMES_PER_UNIT_DEFAULT = 60;
  localparam int LOW_THRESHOLD_DEFAULT   = 20;
  localparam int REFILL_AMOUNT_DEFAULT   = 30;
  localparam int CRASH_PENALTY_DEFAULT   = 5;
  localparam int BLINK_FRAMES_DEFAULT    = 16;

  localparam int FUEL_LEVEL_W = 7;

  // Saturates a signed intermediate level into 0..max_level.
  function automatic logic [FUEL_LEVEL_W-1:0] clamp_level(
    input logic signed [8:0]        v,
    input logic [FUEL_LEVEL_W-1:0]  max_level
  );
    if (v[8]) begin
      return '0;
    end
    if (v[7:0] > {1'b0, max_level}) begin
      return max_level;
    end
    return v[FUEL_LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Counts enabled ticks modulo PERIOD; wrap is high combinationally on the
// tick that rolls the counter back to zero, so the caller sees it that cycle.
module frame_divider #(
  parameter int WIDTH  = 6,
  parameter int PERIOD = 60
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic tick,
  output logic wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

  logic [WIDTH-1:0] count;

  assign wrap = tick && !clear && (count == LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/fuel_controller.sv
// Player fuel bookkeeping: burns fuel while driving, applies refills and crash
// penalties with saturation, and drives the FUEL label blink and gauge.
module fuel_controller
  import road_fighter_pkg::*;
#(
  parameter int FUEL_MAX        = FUEL_MAX_DEFAULT,
  parameter int FRAMES_PER_UNIT = FRAMES_PER_UNIT_DEFAULT,
  parameter int LOW_THRESHOLD   = LOW_THRESHOLD_DEFAULT,
  parameter int REFILL_AMOUNT   = REFILL_AMOUNT_DEFAULT,
  parameter int CRASH_PENALTY   = CRASH_PENALTY_DEFAULT,
  parameter int BLINK_FRAMES    = BLINK_FRAMES_DEFAULT
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       gameStart,
  input  logic       driving,
  input  logic       fuelPickup,
  input  logic       crash,
  output logic [6:0] fuelLevel,
  output logic [6:0] gaugeLength,
  output logic       lowFuel,
  output logic       labelEnable,
  output logic       fuelEmpty,
  output logic [1:0] fuelState
);

  localparam logic [1:0] S_IDLE  = FUEL_IDLE;
  localparam logic [1:0] S_RUN   = FUEL_RUN;
  localparam logic [1:0] S_LOW   = FUEL_LOW;
  localparam logic [1:0] S_EMPTY = FUEL_EMPTY;

  localparam logic [6:0]        MAX_LVL = 7'(FUEL_MAX);
  localparam logic [6:0]        LOW_LVL = 7'(LOW_THRESHOLD);
  localparam logic signed [8:0] REFILL  = 9'(REFILL_AMOUNT);
  localparam logic signed [8:0] PENALTY = 9'(CRASH_PENALTY);
  localparam int                BLINK_W = $clog2(BLINK_FRAMES + 1);

  logic [1:0]        state, state_nxt, state_upd;
  logic [6:0]        level, level_nxt, level_upd;
  logic signed [8:0] level_sum;
  logic              burning;
  logic              burn, burn_clear, burn_tick;
  logic              blink_wrap, blink_clear, blink_tick;

  // Event inputs are single-cycle pulses with no back-pressure: each one is
  // consumed in the cycle it is high, and gameStart overrides everything else.
  assign burning     = (state == S_RUN) || (state == S_LOW);
  assign burn_clear  = gameStart || !burning;
  assign burn_tick   = startOfFrame && driving && burning;
  assign blink_clear = gameStart || (state != S_LOW);
  assign blink_tick  = startOfFrame && (state == S_LOW);

  frame_divider #(
    .WIDTH  (6),
    .PERIOD (FRAMES_PER_UNIT)
  ) u_burn_div (
    .clk    (clk),
    .resetN (resetN),
    .clear  (burn_clear),
    .tick   (burn_tick),
    .wrap   (burn)
  );

  frame_divider #(
    .WIDTH  (BLINK_W),
    .PERIOD (BLINK_FRAMES)
  ) u_blink_div (
    .clk    (clk),
    .resetN (resetN),
    .clear  (blink_clear),
    .tick   (blink_tick),
    .wrap   (blink_wrap)
  );

  always_comb begin
    level_sum = $signed({2'b00, level})
              + (fuelPickup ? REFILL : 9'sd0)
              - $signed({8'd0, burn})
              - (crash ? PENALTY : 9'sd0);
    level_upd = clamp_level(level_sum, MAX_LVL);

    if (level_upd == 7'd0) begin
      state_upd = S_EMPTY;
    end else if (level_upd <= LOW_LVL) begin
      state_upd = S_LOW;
    end else begin
      state_upd = S_RUN;
    end

    level_nxt = level;
    state_nxt = state;
    if (gameStart) begin
      level_nxt = MAX_LVL;
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_IDLE: begin
          level_nxt = MAX_LVL;
        end
        S_RUN, S_LOW: begin
          level_nxt = level_upd;
          state_nxt = state_upd;
        end
        S_EMPTY: begin
          level_nxt = 7'd0;
        end
        default: begin
          level_nxt = MAX_LVL;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      level       <= MAX_LVL;
      lowFuel     <= 1'b0;
      labelEnable <= 1'b1;
      fuelEmpty   <= 1'b0;
    end else begin
      state     <= state_nxt;
      level     <= level_nxt;
      lowFuel   <= (state_nxt == S_LOW);
      fuelEmpty <= (state_nxt == S_EMPTY) && (state != S_EMPTY);
      // The label restarts lit whenever LOW is entered and only blinks while staying there.
      if ((state_nxt != S_LOW) || (state != S_LOW)) begin
        labelEnable <= 1'b1;
      end else if (blink_wrap) begin
        labelEnable <= ~labelEnable;
      end
    end
  end

  assign fuelLevel   = level;
  assign gaugeLength = level;
  assign fuelState   = state;

endmodule

// File: tb/tb_fuel_controller.sv
// Directed bench for fuel_controller with a reference model feeding an
// expected queue, plus fixed checks at the scenario milestones.
module tb_fuel_controller;

  localparam int FM  = 10;
  localparam int FPU = 2;
  localparam int LT  = 3;
  localparam int RA  = 4;
  localparam int CP  = 2;
  localparam int BF  = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_EMPTY = 2'd3;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame, gameStart, driving, fuelPickup, crash;
  logic [6:0] fuelLevel, gaugeLength;
  logic       lowFuel, labelEnable, fuelEmpty;
  logic [1:0] fuelState;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];

  int         m_level, m_fc, m_bc;
  logic [1:0] m_state;
  logic       m_le;

  fuel_controller #(
    .FUEL_MAX        (FM),
    .FRAMES_PER_UNIT (FPU),
    .LOW_THRESHOLD   (LT),
    .REFILL_AMOUNT   (RA),
    .CRASH_PENALTY   (CP),
    .BLINK_FRAMES    (BF)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .gameStart    (gameStart),
    .driving      (driving),
    .fuelPickup   (fuelPickup),
    .crash        (crash),
    .fuelLevel    (fuelLevel),
    .gaugeLength  (gaugeLength),
    .lowFuel      (lowFuel),
    .labelEnable  (labelEnable),
    .fuelEmpty    (fuelEmpty),
    .fuelState    (fuelState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_level = FM;
    m_state = S_IDLE;
    m_fc    = 0;
    m_bc    = 0;
    m_le    = 1'b1;
  endtask

  // One clock of stimulus; the model result is queued, then popped and compared after the edge.
  task automatic step(input logic sof, input logic drv, input logic pick,
                      input logic crs, input logic gs);
    int          n;
    logic        burn, tog, empty_pulse;
    logic [1:0]  ns;
    logic [11:0] e;
    startOfFrame = sof;
    driving      = drv;
    fuelPickup   = pick;
    crash        = crs;
    gameStart    = gs;
    empty_pulse  = 1'b0;
    if (gs) begin
      m_level = FM;
      m_fc    = 0;
      m_bc    = 0;
      m_state = S_RUN;
      m_le    = 1'b1;
    end else if (m_state == S_RUN || m_state == S_LOW) begin
      burn = 1'b0;
      if (sof && drv) begin
        if (m_fc == FPU - 1) begin
          m_fc = 0;
          burn = 1'b1;
        end else begin
          m_fc++;
        end
      end
      n = m_level + (pick ? RA : 0) - (burn ? 1 : 0) - (crs ? CP : 0);
      if (n < 0) n = 0;
      if (n > FM) n = FM;
      ns = (n == 0) ? S_EMPTY : ((n <= LT) ? S_LOW : S_RUN);
      tog = 1'b0;
      if (m_state == S_LOW && sof) begin
        if (m_bc == BF - 1) begin
          m_bc = 0;
          tog  = 1'b1;
        end else begin
          m_bc++;
        end
      end
      if (ns != S_LOW || m_state != S_LOW) begin
        m_le = 1'b1;
        m_bc = 0;
      end else if (tog) begin
        m_le = ~m_le;
      end
      empty_pulse = (ns == S_EMPTY);
      m_level = n;
      m_state = ns;
    end else begin
      m_fc    = 0;
      m_bc    = 0;
      m_le    = 1'b1;
      m_level = (m_state == S_EMPTY) ? 0 : FM;
    end
    e = {7'(m_level), (m_state == S_LOW), m_le, empty_pulse, m_state};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb_level",   fuelLevel,          e[11:5]);
    chk("sb_gauge",   gaugeLength,        e[11:5]);
    chk("sb_lowFuel", {6'd0, lowFuel},     {6'd0, e[4]});
    chk("sb_label",   {6'd0, labelEnable}, {6'd0, e[3]});
    chk("sb_empty",   {6'd0, fuelEmpty},   {6'd0, e[2]});
    chk("sb_state",   {5'd0, fuelState},   {5'd0, e[1:0]});
    startOfFrame = 1'b0;
    driving      = 1'b0;
    fuelPickup   = 1'b0;
    crash        = 1'b0;
    gameStart    = 1'b0;
  endtask

  task automatic frame(input logic drv, input logic pick, input logic crs);
    step(1'b1, drv, pick, crs, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_level"}, fuelLevel,              7'(FM));
    chk({tag, "_gauge"}, gaugeLength,            7'(FM));
    chk({tag, "_low"},   {6'd0, lowFuel},     7'd0);
    chk({tag, "_label"}, {6'd0, labelEnable}, 7'd1);
    chk({tag, "_empty"}, {6'd0, fuelEmpty},   7'd0);
    chk({tag, "_state"}, {5'd0, fuelState},   {5'd0, S_IDLE});
  endtask

  initial begin
    logic [3:0] le_pat;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    gameStart    = 1'b0;
    driving      = 1'b0;
    fuelPickup   = 1'b0;
    crash        = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // Start a run and burn one unit per two driving frames.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("start_state", {5'd0, fuelState}, {5'd0, S_RUN});
    repeat (2) frame(1'b1, 1'b0, 1'b0);
    chk("burn_9", fuelLevel, 7'd9);
    repeat (2) frame(1'b1, 1'b0, 1'b0);
    chk("burn_8", fuelLevel, 7'd8);
    chk("burn_low", {6'd0, lowFuel}, 7'd0);

    // Not driving: nothing burns.
    repeat (4) frame(1'b0, 1'b0, 1'b0);
    chk("frozen", fuelLevel, 7'd8);

    // Drive down to the threshold.
    repeat (10) frame(1'b1, 1'b0, 1'b0);
    chk("low_level", fuelLevel, 7'd3);
    chk("low_flag", {6'd0, lowFuel}, 7'd1);
    chk("low_entry_label", {6'd0, labelEnable}, 7'd1);

    // Label blink across successive frames while parked in LOW.
    le_pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("blink", {6'd0, labelEnable}, {6'd0, le_pat[3-i]});
      idle();
    end

    // Pickup and burn on the same frame.
    frame(1'b1, 1'b0, 1'b0);
    chk("pre_combo", fuelLevel, 7'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("combo_level", fuelLevel, 7'd6);
    chk("combo_state", {5'd0, fuelState}, {5'd0, S_RUN});
    chk("combo_label", {6'd0, labelEnable}, 7'd1);
    idle();

    // Refill saturation at the top of the tank.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("refill_10", fuelLevel, 7'd10);
    repeat (2) frame(1'b1, 1'b0, 1'b0);
    chk("before_sat", fuelLevel, 7'd9);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat", fuelLevel, 7'd10);

    // gameStart wins over simultaneous pickup and crash.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("gs_priority", fuelLevel, 7'd10);

    // Crashes down into LOW, burn to 1, then a crash empties the tank.
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("crash_2", fuelLevel, 7'd2);
    chk("crash_low", {6'd0, lowFuel}, 7'd1);
    repeat (2) frame(1'b1, 1'b0, 1'b0);
    chk("level_1", fuelLevel, 7'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_level", fuelLevel, 7'd0);
    chk("empty_pulse", {6'd0, fuelEmpty}, 7'd1);
    chk("empty_state", {5'd0, fuelState}, {5'd0, S_EMPTY});
    idle();
    chk("empty_pulse_end", {6'd0, fuelEmpty}, 7'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("empty_pickup", fuelLevel, 7'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_crash_state", {5'd0, fuelState}, {5'd0, S_EMPTY});
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_level", fuelLevel, 7'd10);
    chk("restart_state", {5'd0, fuelState}, {5'd0, S_RUN});

    // Back into LOW, then an asynchronous reset mid-cycle.
    repeat (14) frame(1'b1, 1'b0, 1'b0);
    chk("low_again", {6'd0, lowFuel}, 7'd1);
    #2;
    resetN = 1'b0;
    #1;
    chk_reset_values("async");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    resetN = 1'b1;
    idle();
    chk("post_reset_state", {5'd0, fuelState}, {5'd0, S_IDLE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
